// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
    localparam int UART_DATA_BITS            = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_if.sv
// Valid/ready byte handshake between the core's store path and the transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface : uart_tx_if

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head entry readable combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Advance each pointer independently so a simultaneous push and pop keeps the count.
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers; reset empties the FIFO at once.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; entries are only read after being written, so it maps to plain RAM.
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule : sync_fifo

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop frame FSM.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_if.slave                    in_if,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int                  CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]    BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]    BAUD_ONE  = CNT_W'(1);
    localparam logic [2:0]          LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          baud_cnt_q, baud_cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      txd_q, txd_d;

    logic                      fifo_push, fifo_pop;
    logic                      fifo_full, fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_rd_data;
    logic                      bit_end;

    assign in_if.in_ready = !fifo_full;
    assign fifo_push      = in_if.in_valid && !fifo_full;
    assign bit_end        = (baud_cnt_q == BAUD_LAST);
    assign busy           = (state_q != IDLE) || !fifo_empty;
    assign txd            = txd_q;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (in_if.in_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Frame sequencing, baud counting, shifting; txd is precomputed from the next state.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_ONE;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) state_d = STOP;
                    else                       bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // FSM, counters and the registered serial line; reset truncates any frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
        end
    end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          txd;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_if bus ();

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_if      (bus),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that put the start bit on txd; ends on the last stop cycle.
    task automatic expect_frame(input string tag, input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            check($sformatf("%s_txd_c%0d", tag, c), 32'(txd), 32'(bits[c / CPB]));
            if (c == 10 * CPB - 1) check($sformatf("%s_busy_end", tag), 32'(busy), 32'd1);
            else tick();
        end
    endtask

    // Wait (bounded) for a start bit, then sample each bit mid-period.
    task automatic rx_byte(input string tag, output logic [7:0] b);
        int w;
        w = 0;
        b = '0;
        while (txd !== 1'b0 && w < 2000) begin
            tick();
            w++;
        end
        check($sformatf("%s_start_seen", tag), 32'(w < 2000), 32'd1);
        if (w >= 2000) return;
        tick(); tick();
        check($sformatf("%s_start_mid", tag), 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) tick();
            b[i] = txd;
        end
        repeat (CPB) tick();
        check($sformatf("%s_stop", tag), 32'(txd), 32'd1);
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 500) begin
            tick();
            w++;
        end
        check($sformatf("%s_idle_reached", tag), 32'(w < 500), 32'd1);
    endtask

    // Six bytes offered back to back; acceptance edges and counts hand-derived.
    task automatic q6_producer();
        int          cyc;
        logic        acc;
        int          exp_edge [6] = '{1, 2, 3, 4, 5, 43};
        logic [31:0] exp_cnt  [6] = '{1, 1, 2, 3, 4, 4};
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_data  = 8'(i + 1);
            bus.in_valid = 1'b1;
            acc = 1'b0;
            while (!acc && cyc < 500) begin
                acc = bus.in_ready;
                tick();
                cyc++;
                if (cyc == 42) begin
                    check("q6_cnt_after_pop", 32'(fifo_count), 32'd3);
                    check("q6_ready_after_pop", 32'(bus.in_ready), 32'd1);
                end
            end
            check($sformatf("q6_accept_edge_%0d", i), 32'(cyc), 32'(exp_edge[i]));
            check($sformatf("q6_count_%0d", i), 32'(fifo_count), exp_cnt[i]);
            if (i == 4) check("q6_ready_full", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic q6_consumer();
        logic [7:0] b;
        for (int i = 0; i < 6; i++) begin
            rx_byte($sformatf("q6_rx%0d", i), b);
            check($sformatf("q6_byte_%0d", i), 32'(b), 32'(i + 1));
        end
    endtask

    // Three bytes queued, then a fourth pushed exactly on the pop edge at count 2.
    task automatic pp_producer();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A; tick();
        bus.in_data  = 8'hC3; tick();
        bus.in_data  = 8'h81; tick();
        bus.in_valid = 1'b0;
        check("pp_count_queued", 32'(fifo_count), 32'd2);
        repeat (38) tick();
        check("pp_count_before", 32'(fifo_count), 32'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h7E;
        tick();
        bus.in_valid = 1'b0;
        check("pp_count_same_edge", 32'(fifo_count), 32'd2);
        check("pp_next_start", 32'(txd), 32'd0);
    endtask

    task automatic pp_consumer();
        logic [7:0] b;
        logic [7:0] exp [4] = '{8'h5A, 8'hC3, 8'h81, 8'h7E};
        for (int i = 0; i < 4; i++) begin
            rx_byte($sformatf("pp_rx%0d", i), b);
            check($sformatf("pp_byte_%0d", i), 32'(b), 32'(exp[i]));
        end
    endtask

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        reset        = 1'b1;

        // Reset values appear before any clock edge.
        #3;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            check("idle_txd", 32'(txd), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ready", 32'(bus.in_ready), 32'd1);
            check("idle_count", 32'(fifo_count), 32'd0);
        end

        // Single byte 0xA5: one-edge latency, 40-cycle frame, busy drop.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        tick();
        bus.in_valid = 1'b0;
        check("a5_txd_latency", 32'(txd), 32'd1);
        check("a5_count", 32'(fifo_count), 32'd1);
        check("a5_busy", 32'(busy), 32'd1);
        tick();
        check("a5_count_popped", 32'(fifo_count), 32'd0);
        expect_frame("a5", 8'hA5);
        tick();
        check("a5_busy_drop", 32'(busy), 32'd0);
        check("a5_txd_idle", 32'(txd), 32'd1);

        // Back-to-back 0x00 then 0xFF with no idle gap.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        tick();
        bus.in_data  = 8'hFF;
        tick();
        bus.in_valid = 1'b0;
        check("b2b_count", 32'(fifo_count), 32'd1);
        expect_frame("b2b0", 8'h00);
        tick();
        expect_frame("b2b1", 8'hFF);
        tick();
        check("b2b_busy_drop", 32'(busy), 32'd0);

        // Producer holds valid through a full FIFO.
        fork
            q6_producer();
            q6_consumer();
        join
        wait_idle("q6");

        // Push coinciding with pop.
        fork
            pp_producer();
            pp_consumer();
        join
        wait_idle("pp");

        // Reset during the DATA phase of 0x3C with two bytes queued.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C; tick();
        bus.in_data  = 8'h01; tick();
        bus.in_data  = 8'h02; tick();
        bus.in_valid = 1'b0;
        check("mr_count_queued", 32'(fifo_count), 32'd2);
        repeat (10) tick();
        check("mr_txd_data_bit1", 32'(txd), 32'd0);
        reset = 1'b1;
        #1;
        check("mr_txd_async", 32'(txd), 32'd1);
        check("mr_count_async", 32'(fifo_count), 32'd0);
        check("mr_busy_async", 32'(busy), 32'd0);
        check("mr_ready_async", 32'(bus.in_ready), 32'd1);
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            check("mr_quiet_txd", 32'(txd), 32'd1);
            check("mr_quiet_busy", 32'(busy), 32'd0);
        end

        // A fresh push after reset is transmitted normally.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h96;
        tick();
        bus.in_valid = 1'b0;
        check("post_txd_latency", 32'(txd), 32'd1);
        tick();
        expect_frame("post", 8'h96);
        tick();
        check("post_busy_drop", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_tx
